spi_rx_display: RTL



---
 rtl/spi_rx_display.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/spi_rx_display.sv
// spi_rx_display
//   Collects the F_NUM ASCII frames of one SPI message into a frame buffer.
//   When the last frame arrives, the whole message is copied into a display
//   register. That register is shown on a 4-digit multiplexed, active-low
//   seven-segment display.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   msg_start_i   one-cycle pulse at CS falling edge
//   rx_valid_i    one-cycle pulse, rx_data_i holds a received frame
//   rx_data_i     received frame (ASCII)
//   msg_done_o    one-cycle pulse the cycle after the F_NUM-th frame is stored
//   ovf_o         sticky, a frame arrived after F_NUM frames of one message
//   abcdefgh      segment lines, active-low, bit7=a .. bit1=g, bit0=h (dp)
//   digit         digit enables, active-low one-hot, digit[3]=leftmost
//
// Optional feature macro: SPI_RX_DISPLAY_DP_OVF_EN
//   When defined, the dp of the leftmost digit lights while ovf_o is set.
module spi_rx_display #(
    parameter int F_SIZE   = 8,
    parameter int F_NUM    = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              msg_start_i,
    input  logic              rx_valid_i,
    input  logic [F_SIZE-1:0] rx_data_i,
    output logic              msg_done_o,
    output logic              ovf_o,
    output logic [7:0]        abcdefgh,
    output logic [3:0]        digit
);

    localparam int PW = $clog2(F_NUM + 1);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PTR_FULL = PW'(F_NUM);
    localparam logic [PW-1:0] PTR_LAST = PW'(F_NUM - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [F_SIZE-1:0] SPACE = F_SIZE'(8'h20);

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     base_ptr;
    logic [F_SIZE-1:0] rx_buf [F_NUM];
    logic [F_SIZE-1:0] disp   [F_NUM];
    logic [CW-1:0]     scan_cnt;
    logic [1:0]        scan_idx;
    logic [F_SIZE-1:0] cur_char;
    logic [7:0]        seg_next;

    function automatic logic [7:0] seg_decode(input logic [F_SIZE-1:0] c);
        logic [7:0] s;
        case (c)
            8'h20:        s = 8'hFF;
            8'h30:        s = 8'h03;
            8'h31:        s = 8'h9F;
            8'h32:        s = 8'h25;
            8'h33:        s = 8'h0D;
            8'h34:        s = 8'h99;
            8'h35:        s = 8'h49;
            8'h36:        s = 8'h41;
            8'h37:        s = 8'h1F;
            8'h38:        s = 8'h01;
            8'h39:        s = 8'h09;
            8'h41, 8'h61: s = 8'h11;
            8'h46:        s = 8'h71;
            8'h47:        s = 8'h43;
            8'h50:        s = 8'h31;
            default:      s = 8'hFD;
        endcase
        return s;
    endfunction

    // A start pulse rewinds the pointer before a coincident frame is stored.
    always_comb begin
        base_ptr = msg_start_i ? '0 : wr_ptr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            msg_done_o <= 1'b0;
            ovf_o      <= 1'b0;
            for (int unsigned i = 0; i < F_NUM; i++) begin
                rx_buf[i] <= SPACE;
                disp[i]   <= SPACE;
            end
        end else begin
            msg_done_o <= 1'b0;
            if (msg_start_i) begin
                ovf_o <= 1'b0;
            end
            if (rx_valid_i && (base_ptr < PTR_FULL)) begin
                wr_ptr <= base_ptr + 1'b1;
                for (int unsigned i = 0; i < F_NUM; i++) begin
                    if (base_ptr == PW'(i)) begin
                        rx_buf[i] <= rx_data_i;
                    end
                end
                if (base_ptr == PTR_LAST) begin
                    msg_done_o <= 1'b1;
                    // The final byte lands in disp directly, bypassing rx_buf.
                    for (int unsigned i = 0; i < F_NUM; i++) begin
                        disp[i] <= (i == F_NUM - 1) ? rx_data_i : rx_buf[i];
                    end
                end
            end else begin
                wr_ptr <= base_ptr;
                if (rx_valid_i) begin
                    ovf_o <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == CNT_LAST) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Digit positions beyond F_NUM keep the space default and show blank.
    always_comb begin
        cur_char = SPACE;
        for (int unsigned i = 0; i < F_NUM; i++) begin
            if (scan_idx == 2'(i)) begin
                cur_char = disp[i];
            end
        end
        seg_next = seg_decode(cur_char);
`ifdef SPI_RX_DISPLAY_DP_OVF_EN
        if ((scan_idx == 2'd0) && ovf_o) begin
            seg_next[0] = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            abcdefgh <= 8'hFF;
            digit    <= 4'hF;
        end else begin
            abcdefgh <= seg_next;
            digit    <= ~(4'b1000 >> scan_idx);
        end
    end

endmodule
